page_leaf_arb: RTL and testbench

PAGE_LEAF_ARB -- requirements
Module: page_leaf_arb

---
 rtl/page_leaf_arb.sv | 162 ++++++++++++++++
 tb/tb_page_leaf_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/page_leaf_arb.sv
// -----------------------------------------------------------------------------
// page_leaf_arb
//   Merges NUM_CH leaf channels onto a single BFT leaf packet output. Each
//   channel has its own FIFO of FIFO_DEPTH payload entries. Each cycle with
//   ap_start high, a round-robin arbiter grants one non-empty channel, pops it
//   and registers {valid=1, payload} on the output. A resend re-drives the last
//   granted packet without popping anything.
//
// Ports
//   clk                      : single clock for all logic
//   reset_n                  : asynchronous active-low reset
//   ap_start                 : enables egress arbitration
//   resend                   : re-drive the last granted packet
//   ch_din                   : per-channel payload, channel i at slice i
//   ch_valid                 : per-channel payload valid
//   ch_ready                 : per-channel FIFO not full
//   dout_leaf_interface2bft  : registered packet, bit PKT_W-1 is the valid flag
//   pkt_cnt                  : grant counter (only with PAGE_LEAF_ARB_STATS_EN)
//
// Configuration
//   PAGE_LEAF_ARB_STATS_EN : when defined, adds the 32-bit pkt_cnt output that
//                            counts grants (resends excluded), wrapping to 0.
// -----------------------------------------------------------------------------
module page_leaf_arb #(
   parameter int NUM_CH     = 6,
   parameter int PKT_W      = 49,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          ap_start,
   input  logic                          resend,
   input  logic [NUM_CH*(PKT_W-1)-1:0]   ch_din,
   input  logic [NUM_CH-1:0]             ch_valid,
   output logic [NUM_CH-1:0]             ch_ready,
   output logic [PKT_W-1:0]              dout_leaf_interface2bft
`ifdef PAGE_LEAF_ARB_STATS_EN
   ,
   output logic [31:0]                   pkt_cnt
`endif
);

   localparam int PW = PKT_W - 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]    w_nonempty;
   logic [NUM_CH-1:0]    w_push;
   logic [NUM_CH-1:0]    w_pop;
   logic [NUM_CH*PW-1:0] w_head_flat;

   logic                 w_gnt_vld;
   logic [GW-1:0]        w_gnt_idx;
   logic [PW-1:0]        w_gnt_pl;
   logic                 w_do_grant;

   logic [GW-1:0]        r_last_grant;
   logic [PW-1:0]        r_last_pl;
   logic                 r_last_vld;
   logic [PKT_W-1:0]     r_dout;

   // ---- Stage: per-channel FIFOs -------------------------------------------
   for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
      logic [PW-1:0] r_mem [FIFO_DEPTH];
      logic [AW-1:0] r_wptr;
      logic [AW-1:0] r_rptr;
      logic [CW-1:0] r_cnt;

      // Ready depends on the count alone, so a full FIFO refuses a push even
      // when it is being popped in the same cycle.
      assign ch_ready[g]               = (r_cnt < CW'(FIFO_DEPTH));
      assign w_nonempty[g]             = (r_cnt != '0);
      assign w_push[g]                 = ch_valid[g] & ch_ready[g];
      assign w_pop[g]                  = w_do_grant & (w_gnt_idx == GW'(g));
      assign w_head_flat[g*PW +: PW]   = r_mem[r_rptr];

      // Storage carries no reset: pointers and count define what is valid.
      always_ff @(posedge clk) begin
         if (w_push[g]) begin
            r_mem[r_wptr] <= ch_din[g*PW +: PW];
         end
      end

      // Pointers wrap naturally since FIFO_DEPTH is a power of two.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
         end else begin
            if (w_push[g]) r_wptr <= r_wptr + AW'(1);
            if (w_pop[g])  r_rptr <= r_rptr + AW'(1);
            case ({w_push[g], w_pop[g]})
               2'b10:   r_cnt <= r_cnt + CW'(1);
               2'b01:   r_cnt <= r_cnt - CW'(1);
               default: r_cnt <= r_cnt;
            endcase
         end
      end
   end

   // ---- Stage: round-robin grant search ------------------------------------
   // Scan offsets from NUM_CH down to 1 so the smallest offset past the last
   // grant is the one left standing.
   always_comb begin
      int t;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_gnt_pl  = '0;
      t         = 0;
      for (int k = NUM_CH; k >= 1; k--) begin
         t = int'(r_last_grant) + k;
         if (t >= NUM_CH) t = t - NUM_CH;
         if (w_nonempty[t]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = GW'(t);
            w_gnt_pl  = w_head_flat[t*PW +: PW];
         end
      end
   end

   assign w_do_grant = ap_start & ~resend & w_gnt_vld;

   // ---- Stage: output register ---------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dout       <= '0;
         r_last_grant <= GW'(NUM_CH - 1);
         r_last_pl    <= '0;
         r_last_vld   <= 1'b0;
      end else if (!ap_start) begin
         r_dout <= '0;
      end else if (resend) begin
         r_dout <= r_last_vld ? {1'b1, r_last_pl} : '0;
      end else if (w_gnt_vld) begin
         r_dout       <= {1'b1, w_gnt_pl};
         r_last_grant <= w_gnt_idx;
         r_last_pl    <= w_gnt_pl;
         r_last_vld   <= 1'b1;
      end else begin
         r_dout <= '0;
      end
   end

   assign dout_leaf_interface2bft = r_dout;

`ifdef PAGE_LEAF_ARB_STATS_EN
   logic [31:0] r_pkt_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pkt_cnt <= '0;
      end else if (w_do_grant) begin
         r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
   end

   assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_page_leaf_arb.sv
module tb_page_leaf_arb;

   localparam int NUM_CH     = 6;
   localparam int PKT_W      = 49;
   localparam int FIFO_DEPTH = 4;
   localparam int PW         = PKT_W - 1;

   logic                    clk;
   logic                    reset_n;
   logic                    ap_start;
   logic                    resend;
   logic [NUM_CH*PW-1:0]    ch_din;
   logic [NUM_CH-1:0]       ch_valid;
   logic [NUM_CH-1:0]       ch_ready;
   logic [PKT_W-1:0]        dout;
`ifdef PAGE_LEAF_ARB_STATS_EN
   logic [31:0]             pkt_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   page_leaf_arb #(
      .NUM_CH     (NUM_CH),
      .PKT_W      (PKT_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .ap_start                (ap_start),
      .resend                  (resend),
      .ch_din                  (ch_din),
      .ch_valid                (ch_valid),
      .ch_ready                (ch_ready),
      .dout_leaf_interface2bft (dout)
`ifdef PAGE_LEAF_ARB_STATS_EN
      ,
      .pkt_cnt                 (pkt_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_din(input int ch, input logic [PW-1:0] v);
      ch_din[ch*PW +: PW] = v;
   endtask

   function automatic logic [63:0] pk(input logic [PW-1:0] v);
      return {15'b0, 1'b1, v};
   endfunction

   initial begin
      reset_n  = 1'b0;
      ap_start = 1'b0;
      resend   = 1'b0;
      ch_din   = '0;
      ch_valid = '0;
      tick();
      tick();
      chk("reset_dout", 64'(dout), 64'h0);
      chk("reset_ready", 64'(ch_ready), 64'h3F);
      reset_n = 1'b1;
      tick();

      // Fairness: two payloads per channel, round-robin from channel 0.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NUM_CH; i++) set_din(i, PW'(i*16 + k));
         ch_valid = '1;
         tick();
      end
      ch_valid = '0;
      chk("fair_idle_dout", 64'(dout), 64'h0);
      ap_start = 1'b1;
      for (int j = 0; j < 2*NUM_CH; j++) begin
         tick();
         chk("fair_order", 64'(dout), pk(PW'((j % NUM_CH)*16 + (j / NUM_CH))));
      end
      tick();
      chk("fair_drained", 64'(dout), 64'h0);
      ap_start = 1'b0;

      // Backpressure: five pushes into a four-deep FIFO on channel 2.
      ch_valid = 6'b000100;
      for (int k = 0; k < 5; k++) begin
         set_din(2, PW'(100 + k));
         tick();
         if (k == 3) chk("bp_full_ready", 64'(ch_ready[2]), 64'h0);
      end
      ch_valid = '0;
      chk("bp_dout_idle", 64'(dout), 64'h0);
      ap_start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp_drain", 64'(dout), pk(PW'(100 + k)));
      end
      tick();
      chk("bp_fifth_refused", 64'(dout), 64'h0);
      ap_start = 1'b0;

      // Resend: 0x1234 on channel 3, channel 4 waiting behind it.
      set_din(3, PW'(48'h1234));
      set_din(4, PW'(48'h4444));
      ch_valid = 6'b011000;
      tick();
      ch_valid = '0;
      ap_start = 1'b1;
      tick();
      chk("rs_grant", 64'(dout), pk(48'h1234));
      resend = 1'b1;
      tick();
      chk("rs_again1", 64'(dout), pk(48'h1234));
      tick();
      chk("rs_again2", 64'(dout), pk(48'h1234));
      resend = 1'b0;
      tick();
      chk("rs_next_ch4", 64'(dout), pk(48'h4444));
      ap_start = 1'b0;
      resend   = 1'b1;
      tick();
      chk("stop_ignores_resend", 64'(dout), 64'h0);
      resend = 1'b0;

      // Reset mid-stream with three payloads queued on every channel.
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < NUM_CH; i++) set_din(i, PW'(12'h500 + i*16 + k));
         ch_valid = '1;
         tick();
      end
      ch_valid = '0;
      ap_start = 1'b1;
      tick();
      chk("pre_reset_grant", 64'(dout), pk(PW'(12'h550)));
      reset_n = 1'b0;
      #1;
      chk("async_reset_dout", 64'(dout), 64'h0);
      chk("async_reset_ready", 64'(ch_ready), 64'h3F);
      tick();
      reset_n = 1'b1;
      resend  = 1'b1;
      tick();
      chk("resend_after_reset", 64'(dout), 64'h0);
      resend = 1'b0;
      tick();
      chk("no_stale_after_reset", 64'(dout), 64'h0);
      set_din(0, PW'(48'hA0));
      set_din(1, PW'(48'hA1));
      ch_valid = 6'b000011;
      tick();
      ch_valid = '0;
      chk("push_edge_empty", 64'(dout), 64'h0);
      tick();
      chk("first_grant_ch0", 64'(dout), pk(48'hA0));
      tick();
      chk("then_ch1", 64'(dout), pk(48'hA1));

      // Wrap and concurrent push/pop on channel 0.
      for (int c = 0; c <= 20; c++) begin
         ch_valid = (c < 20) ? 6'b000001 : 6'b000000;
         set_din(0, PW'(c));
         tick();
         chk("wrap_ready0", 64'(ch_ready[0]), 64'h1);
         if (c >= 1) chk("wrap_order", 64'(dout), pk(PW'(c - 1)));
      end
      ch_valid = '0;
      tick();
      chk("wrap_drained", 64'(dout), 64'h0);

`ifdef PAGE_LEAF_ARB_STATS_EN
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("stats_reset", 64'(pkt_cnt), 64'h0);
      for (int c = 0; c < 10; c++) begin
         ch_valid = 6'b000001;
         set_din(0, PW'(c));
         tick();
      end
      ch_valid = '0;
      tick();
      resend = 1'b1;
      repeat (3) tick();
      resend = 1'b0;
      chk("stats_ten", 64'(pkt_cnt), 64'd10);
      dut.r_pkt_cnt = 32'hFFFF_FFFF;
      ch_valid = 6'b000001;
      set_din(0, PW'(48'h77));
      tick();
      ch_valid = '0;
      tick();
      chk("stats_wrap", 64'(pkt_cnt), 64'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
